// File: rtl/aes_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aes_pkg
// Purpose  : Shared AES-128 definitions: controller FSM state encoding,
//            register load/round select encodings, round count, initial
//            round constant and the GF(2^8) xtime helper (also used by the
//            MixColumns datapath).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package aes_pkg;

    // Number of cipher rounds for a 128-bit key.
    localparam logic [3:0] NR        = 4'd10;
    // Round constant used by the key expansion in round 1.
    localparam logic [7:0] RCON_INIT = 8'h01;

    // state_sel encodings
    localparam logic STATE_SEL_LOAD  = 1'b0;   // plaintext XOR cipher key
    localparam logic STATE_SEL_ROUND = 1'b1;   // round function output

    // key_sel encodings
    localparam logic KEY_SEL_LOAD    = 1'b0;   // raw cipher key
    localparam logic KEY_SEL_EXPAND  = 1'b1;   // next expanded round key

    // Controller FSM states. The load happens in the IDLE accept cycle,
    // so there is no separate LOAD state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aes128_round_ctrl
// Purpose  : Sequencer for an iterative AES-128 encryption datapath. Accepts
//            a block/key pair, drives the state/round-key register controls
//            through the initial AddRoundKey and 10 rounds, supplies round
//            number, rcon and last-round flag, then presents the result.
//            Holds no data itself.
// Ports    : clk, rst         clock, synchronous active-high reset
//            in_valid/in_ready    input handshake (plaintext + key)
//            out_valid/out_ready  output handshake (ciphertext)
//            state_en/state_sel   state register enable / source select
//            key_en/key_sel       round-key register enable / source select
//            round, rcon          current round (0..10) and round constant
//            last_round           round 10: datapath bypasses MixColumns
//            busy                 rounds in progress
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module aes128_round_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       state_en,
    output logic       state_sel,
    output logic       key_en,
    output logic       key_sel,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       last_round,
    output logic       busy
);

    state_t     r_state;
    logic [3:0] r_round;
    logic [7:0] r_rcon;

    state_t     w_state_nxt;
    logic [3:0] w_round_nxt;
    logic [7:0] w_rcon_nxt;

    // State register together with the round counter and rcon register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= 4'd0;
            r_rcon  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_rcon  <= w_rcon_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_rcon_nxt  = r_rcon;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_ROUND;
                    w_round_nxt = 4'd1;
                    w_rcon_nxt  = RCON_INIT;
                end
            end
            ST_ROUND: begin
                // Round and rcon freeze at their round-10 values in DONE.
                if (r_round == NR) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                    w_rcon_nxt  = xtime(r_rcon);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_round_nxt = 4'd0;
                    w_rcon_nxt  = 8'h00;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_round_nxt = 4'd0;
                w_rcon_nxt  = 8'h00;
            end
        endcase
    end

    // Output decode. The only input-dependent outputs are the IDLE load
    // enables, which must fire in the same cycle as the accept.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        state_en   = 1'b0;
        state_sel  = STATE_SEL_LOAD;
        key_en     = 1'b0;
        key_sel    = KEY_SEL_LOAD;
        last_round = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                state_en = in_valid;
                key_en   = in_valid;
            end
            ST_ROUND: begin
                busy       = 1'b1;
                state_en   = 1'b1;
                state_sel  = STATE_SEL_ROUND;
                key_en     = 1'b1;
                key_sel    = KEY_SEL_EXPAND;
                last_round = (r_round == NR);
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign round = r_round;
    assign rcon  = r_rcon;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_aes128_round_ctrl
// Purpose  : Self-checking bench for aes128_round_ctrl. A behavioural AES
//            round/key-expansion datapath is driven by the controller outputs
//            so that complete ciphertexts can be compared to FIPS-197 vectors.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_aes128_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic       state_en;
    logic       state_sel;
    logic       key_en;
    logic       key_sel;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       last_round;
    logic       busy;

    always #5 clk = ~clk;

    aes128_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_en   (state_en),
        .state_sel  (state_sel),
        .key_en     (key_en),
        .key_sel    (key_sel),
        .round      (round),
        .rcon       (rcon),
        .last_round (last_round),
        .busy       (busy)
    );

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Reference AES datapath
    //--------------------------------------------------------------------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv;
            logic [7:0] b;
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(i[7:0], j[7:0]) == 8'h01) inv = j[7:0];
            b = inv;
            sbox[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic lst);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[4*c+rr] = a[4*((c+rr)%4)+rr];
        if (!lst) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
                b[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
                b[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
                b[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    logic [127:0] pt, key, st, kr;

    always @(posedge clk) begin
        if (state_en) st <= state_sel ? aes_round(st, next_key(kr, rcon), last_round) : (pt ^ key);
        if (key_en)   kr <= key_sel ? next_key(kr, rcon) : key;
    end

    //--------------------------------------------------------------------------
    // Vector table: one record per cycle of a full transaction
    //--------------------------------------------------------------------------
    typedef struct {
        logic       iv;
        logic       ordy;
        logic [3:0] rnd;
        logic [7:0] rc;
        logic       lst;
        logic       bsy;
        logic       irdy;
        logic       ov;
        logic       sen;
        logic       ssel;
        logic       ken;
        logic       ksel;
    } vec_t;

    vec_t       tbl [14];
    logic [7:0] rc_seq [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int acc_cyc [$];
        int n_out;
        logic [127:0] exp_ct;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        pt = PT_A; key = KEY_A;

        // Accept cycle
        tbl[0] = '{iv:1'b1, ordy:1'b0, rnd:4'd0, rc:8'h00, lst:1'b0, bsy:1'b0,
                   irdy:1'b1, ov:1'b0, sen:1'b1, ssel:1'b0, ken:1'b1, ksel:1'b0};
        // Rounds 1..10; in_valid pulses at rounds 3 and 7, out_ready held high
        for (int i = 1; i <= 10; i++)
            tbl[i] = '{iv:(i == 3 || i == 7), ordy:1'b1, rnd:i[3:0], rc:rc_seq[i],
                       lst:(i == 10), bsy:1'b1, irdy:1'b0, ov:1'b0,
                       sen:1'b1, ssel:1'b1, ken:1'b1, ksel:1'b1};
        // DONE with in_valid pulsed, handshake completes
        tbl[11] = '{iv:1'b1, ordy:1'b1, rnd:4'd10, rc:8'h36, lst:1'b0, bsy:1'b0,
                    irdy:1'b0, ov:1'b1, sen:1'b0, ssel:1'b0, ken:1'b0, ksel:1'b0};
        // Back in IDLE, no queued block
        for (int i = 12; i < 14; i++)
            tbl[i] = '{iv:1'b0, ordy:1'b0, rnd:4'd0, rc:8'h00, lst:1'b0, bsy:1'b0,
                       irdy:1'b1, ov:1'b0, sen:1'b0, ssel:1'b0, ken:1'b0, ksel:1'b0};

        // ---- Reset values ----
        step(); step();
        @(negedge clk);
        check("rst_round", round, 4'd0);
        check("rst_rcon", rcon, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state_en", state_en, 1'b0);
        check("rst_key_en", key_en, 1'b0);
        check("rst_state_sel", state_sel, 1'b0);
        check("rst_key_sel", key_sel, 1'b0);
        check("rst_last_round", last_round, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        step();

        // ---- Single block, table driven (also busy-ignore) ----
        n_out = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("t%0d_round", i), round, tbl[i].rnd);
            if (!tbl[i].ov) check($sformatf("t%0d_rcon", i), rcon, tbl[i].rc);
            check($sformatf("t%0d_last", i), last_round, tbl[i].lst);
            check($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("t%0d_in_ready", i), in_ready, tbl[i].irdy);
            check($sformatf("t%0d_out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("t%0d_state_en", i), state_en, tbl[i].sen);
            check($sformatf("t%0d_key_en", i), key_en, tbl[i].ken);
            if (tbl[i].sen) check($sformatf("t%0d_state_sel", i), state_sel, tbl[i].ssel);
            if (tbl[i].ken) check($sformatf("t%0d_key_sel", i), key_sel, tbl[i].ksel);
            if (out_valid) n_out++;
            if (i == 11) check("single_ct", st, CT_A);
            step();
        end
        check("single_block_count", n_out, 1);

        // ---- Back-pressure ----
        pt = PT_B; key = KEY_B;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("bp_accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("bp_latency", cyc + 1, 11);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_state_en", state_en, 1'b0);
            check("bp_key_en", key_en, 1'b0);
            check("bp_round", round, 4'd10);
            check("bp_ct", st, CT_B);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_out_valid", out_valid, 1'b1);
        check("bp_hs_in_ready", in_ready, 1'b0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_in_ready", in_ready, 1'b1);
        check("bp_after_out_valid", out_valid, 1'b0);
        step();

        // ---- Reset mid-operation ----
        pt = PT_B; key = KEY_B;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (round != 4'd5 && cyc < 12) begin
            step();
            cyc++;
        end
        check("mid_reached_round5", round, 4'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_round", round, 4'd0);
        check("mid_rst_rcon", rcon, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        step();
        pt = PT_A; key = KEY_A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("mid_after_out_valid", out_valid, 1'b1);
        check("mid_after_ct", st, CT_A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // ---- Back-to-back ----
        pt = PT_A; key = KEY_A;
        in_valid = 1'b1; out_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 40; c++) begin
            logic acc;
            @(negedge clk);
            acc = in_valid & in_ready;
            if (acc) acc_cyc.push_back(c);
            if (out_valid) begin
                exp_ct = (n_out % 2 == 0) ? CT_A : CT_B;
                check($sformatf("b2b_ct%0d", n_out), st, exp_ct);
                n_out++;
            end
            step();
            if (acc) begin
                pt  = (pt == PT_A) ? PT_B : PT_A;
                key = (key == KEY_A) ? KEY_B : KEY_A;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_accepts", acc_cyc.size(), 4);
        check("b2b_outputs", n_out, 3);
        for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("b2b_period%0d", i), acc_cyc[i] - acc_cyc[i-1], 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
